rx_cmd_seq: RTL and testbench



---
 rtl/rx_cmd_seq_pkg.sv | 39 +++
 rtl/rx_cmd_seq_fifo.sv | 53 +++++
 rtl/rx_cmd_seq.sv | 158 +++++++++++++++
 tb/tb_rx_cmd_seq.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_cmd_seq_pkg.sv
// Shared types and constants for the remote-IO command sequencer:
// FSM states, link master register map and command word layout.
package rx_cmd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        WACK,
        WAIT_RSP
    } state_t;

    localparam logic [1:0] LM_ADDR_CMD    = 2'd0;
    localparam logic [1:0] LM_ADDR_DELAY  = 2'd1;
    localparam logic [1:0] LM_ADDR_STREAM = 2'd2;

    localparam int CMD_READ_BIT = 20;
    localparam int CMD_ADDR_HI  = 19;
    localparam int CMD_ADDR_LO  = 16;
    localparam int CMD_DATA_HI  = 15;
    localparam int CMD_DATA_LO  = 0;
    localparam int REQ_W        = CMD_READ_BIT + 1;

    localparam int FRAME_LEN = 512;
    localparam int OFS_W     = $clog2(FRAME_LEN);

    localparam logic [OFS_W-1:0] WACK_OFS = OFS_W'(20);

    function automatic logic [31:0] pack_cmd(input logic rd,
                                             input logic [3:0] a,
                                             input logic [15:0] d);
        logic [31:0] w;
        w = '0;
        w[CMD_READ_BIT]            = rd;
        w[CMD_ADDR_HI:CMD_ADDR_LO] = a;
        w[CMD_DATA_HI:CMD_DATA_LO] = d;
        return w;
    endfunction

endpackage

// File: rtl/rx_cmd_seq_fifo.sv
// Synchronous power-of-two FIFO with full/empty flags; a push is still taken
// when full provided a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/rx_cmd_seq.sv
// Host-side command sequencer: queues register requests, issues one per link
// frame to the link master, captures read data and forwards config writes.
import rx_cmd_seq_pkg::*;

module rx_cmd_seq #(
    parameter int FIFO_DEPTH = 4,
    parameter int ISSUE_OFS  = 2,
    parameter int RSP_LO     = 480,
    parameter int RSP_HI     = 511
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        frame_sync,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_read,
    input  logic [3:0]  req_addr,
    input  logic [15:0] req_data,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [1:0]  cfg_addr,
    input  logic [31:0] cfg_data,
    output logic        wvalid,
    output logic [1:0]  addr,
    output logic [31:0] wdata,
    input  logic        rvalid,
    input  logic [31:0] rdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err
);
    localparam logic [OFS_W-1:0] ISSUE_AT  = OFS_W'(ISSUE_OFS);
    localparam logic [OFS_W-1:0] RSP_LO_AT = OFS_W'(RSP_LO);
    localparam logic [OFS_W-1:0] RSP_HI_AT = OFS_W'(RSP_HI);
    localparam logic [OFS_W-1:0] WIN_SPAN  = RSP_HI_AT - RSP_LO_AT;

    logic [OFS_W-1:0] cnt;
    logic [OFS_W-1:0] offset;
    logic             synced;
    state_t           state;
    state_t           state_nx;

    logic [REQ_W-1:0] head;
    logic [REQ_W-1:0] cmd;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             issue;
    logic             cfg_fire;
    logic             in_window;
    logic             rsp_fire;
    logic             rsp_err_nx;
    logic [15:0]      rsp_data_nx;
    logic             unused_rdata_hi;

    // The master's frame counter is 0 in the frame_sync cycle itself, so the
    // pulse overrides the local count combinationally.
    assign offset    = frame_sync ? '0 : cnt;
    assign in_window = (offset - RSP_LO_AT) <= WIN_SPAN;

    assign req_ready = !fifo_full;
    assign cfg_ready = !(state == ARMED && offset == ISSUE_AT);
    assign cfg_fire  = cfg_valid && cfg_ready &&
                       (cfg_addr == LM_ADDR_DELAY || cfg_addr == LM_ADDR_STREAM);

    assign unused_rdata_hi = ^rdata[31:16];

    sync_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (req_valid && req_ready),
        .wr_data ({req_read, req_addr, req_data}),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_nx    = state;
        pop         = 1'b0;
        issue       = 1'b0;
        rsp_fire    = 1'b0;
        rsp_err_nx  = 1'b0;
        rsp_data_nx = '0;
        case (state)
            IDLE: begin
                if (synced && !fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = ARMED;
                end
            end
            ARMED: begin
                if (offset == ISSUE_AT) begin
                    issue    = 1'b1;
                    state_nx = cmd[CMD_READ_BIT] ? WAIT_RSP : WACK;
                end
            end
            WACK: begin
                if (offset == WACK_OFS) begin
                    rsp_fire = 1'b1;
                    state_nx = IDLE;
                end
            end
            WAIT_RSP: begin
                // A beat on the last window offset still counts as a capture.
                if (rvalid && in_window) begin
                    rsp_fire    = 1'b1;
                    rsp_data_nx = rdata[15:0];
                    state_nx    = IDLE;
                end else if (offset == RSP_HI_AT) begin
                    rsp_fire   = 1'b1;
                    rsp_err_nx = 1'b1;
                    state_nx   = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt       <= '0;
            synced    <= 1'b0;
            state     <= IDLE;
            wvalid    <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            cnt    <= offset + OFS_W'(1);
            state  <= state_nx;
            wvalid <= issue || cfg_fire;
            if (frame_sync) synced <= 1'b1;
            if (issue) begin
                addr  <= LM_ADDR_CMD;
                wdata <= pack_cmd(cmd[CMD_READ_BIT], cmd[CMD_ADDR_HI:CMD_ADDR_LO],
                                  cmd[CMD_DATA_HI:CMD_DATA_LO]);
            end else if (cfg_fire) begin
                addr  <= cfg_addr;
                wdata <= cfg_data;
            end
            rsp_valid <= rsp_fire;
            rsp_data  <= rsp_data_nx;
            rsp_err   <= rsp_err_nx;
        end
    end

    always_ff @(posedge clock) begin
        if (pop) cmd <= head;
    end

endmodule

// File: tb/tb_rx_cmd_seq.sv
// Directed bench for rx_cmd_seq: a free-running model of the master frame
// counter drives frame_sync; each task checks exact frame offsets of outputs.
module tb_rx_cmd_seq;

    logic        clock     = 1'b0;
    logic        reset_n   = 1'b0;
    logic        sync_en   = 1'b0;
    logic [8:0]  mofs      = '0;
    logic        frame_sync;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_read  = 1'b0;
    logic [3:0]  req_addr  = '0;
    logic [15:0] req_data  = '0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_addr  = '0;
    logic [31:0] cfg_data  = '0;
    logic        wvalid;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        rvalid    = 1'b0;
    logic [31:0] rdata     = '0;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;

    int n_vec = 0;
    int n_bad = 0;

    always #4 clock = ~clock;
    always @(posedge clock) mofs <= mofs + 9'd1;
    assign frame_sync = sync_en && (mofs == 9'd0);

    rx_cmd_seq #(
        .FIFO_DEPTH (4),
        .ISSUE_OFS  (2),
        .RSP_LO     (480),
        .RSP_HI     (511)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .frame_sync (frame_sync),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_read   (req_read),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .wvalid     (wvalid),
        .addr       (addr),
        .wdata      (wdata),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    // Advance to the falling edge inside the cycle whose master offset is o.
    task automatic goto_ofs(input int o);
        @(negedge clock);
        while (mofs != 9'(o)) @(negedge clock);
    endtask

    task automatic push_req(input logic rd, input logic [3:0] a, input logic [15:0] d);
        req_valid = 1'b1;
        req_read  = rd;
        req_addr  = a;
        req_data  = d;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        n_vec++;
        if ({wvalid, addr, wdata, rsp_valid, rsp_data, rsp_err} !== 52'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: wvalid=%0b addr=%0d wdata=%h rsp_valid=%0b rsp_data=%h rsp_err=%0b, want all 0",
                     wvalid, addr, wdata, rsp_valid, rsp_data, rsp_err);
        end
        reset_n = 1'b1;
        @(negedge clock);
        n_vec++;
        if ({req_ready, cfg_ready} !== 2'b11) begin
            n_bad++;
            $display("FAIL reset_ready: req_ready=%0b cfg_ready=%0b, want 1 1", req_ready, cfg_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic        rd [5];
        logic [3:0]  ad [5];
        logic [15:0] dt [5];
        logic [31:0] exp_wd [5];
        int saw_wv;
        int saw_rdy;
        rd[0] = 1'b0; ad[0] = 4'h1; dt[0] = 16'h1111; exp_wd[0] = 32'h0001_1111;
        rd[1] = 1'b1; ad[1] = 4'h2; dt[1] = 16'h0000; exp_wd[1] = 32'h0012_0000;
        rd[2] = 1'b0; ad[2] = 4'h3; dt[2] = 16'h3333; exp_wd[2] = 32'h0003_3333;
        rd[3] = 1'b1; ad[3] = 4'h4; dt[3] = 16'h0000; exp_wd[3] = 32'h0014_0000;
        rd[4] = 1'b1; ad[4] = 4'h6; dt[4] = 16'h0000; exp_wd[4] = 32'h0016_0000;
        // Unsynced: nothing drains, so the queue fills after four pushes.
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_read  = rd[i];
            req_addr  = ad[i];
            req_data  = dt[i];
            n_vec++;
            if (req_ready !== (i < 4)) begin
                n_bad++;
                $display("FAIL b2b_ready_%0d: req_ready=%0b want %0b", i, req_ready, (i < 4));
            end
            if (i < 4) @(negedge clock);
        end
        saw_wv  = 0;
        saw_rdy = 0;
        repeat (600) begin
            @(negedge clock);
            if (wvalid)    saw_wv++;
            if (req_ready) saw_rdy++;
        end
        n_vec++;
        if (saw_wv !== 0) begin
            n_bad++;
            $display("FAIL unsynced_issue: wvalid seen %0d cycles, want 0", saw_wv);
        end
        n_vec++;
        if (saw_rdy !== 0) begin
            n_bad++;
            $display("FAIL full_ready: req_ready high %0d cycles, want 0", saw_rdy);
        end
        goto_ofs(500);
        sync_en = 1'b1;
        goto_ofs(1);
        n_vec++;
        if (req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_ready_ofs1: req_ready=%0b want 0", req_ready);
        end
        @(negedge clock);
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_ready_ofs2: req_ready=%0b want 1", req_ready);
        end
        @(negedge clock);
        req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) goto_ofs(3);
            n_vec++;
            if ({wvalid, addr, wdata} !== {1'b1, 2'd0, exp_wd[k]}) begin
                n_bad++;
                $display("FAIL b2b_issue_%0d: wvalid=%0b addr=%0d wdata=%h, want 1 0 %h",
                         k, wvalid, addr, wdata, exp_wd[k]);
            end
            case (k)
                0, 2: begin
                    goto_ofs(21);
                    n_vec++;
                    if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 16'h0}) begin
                        n_bad++;
                        $display("FAIL b2b_wack_%0d: valid=%0b err=%0b data=%h, want 1 0 0000",
                                 k, rsp_valid, rsp_err, rsp_data);
                    end
                end
                1: begin
                    goto_ofs(479);
                    rvalid = 1'b1;
                    rdata  = 32'h0000_BAD0;
                    @(negedge clock);
                    rdata  = 32'h0000_2222;
                    n_vec++;
                    if (rsp_valid !== 1'b0) begin
                        n_bad++;
                        $display("FAIL b2b_rvalid_479: rsp_valid=%0b want 0", rsp_valid);
                    end
                    @(negedge clock);
                    rvalid = 1'b0;
                    n_vec++;
                    if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 16'h2222}) begin
                        n_bad++;
                        $display("FAIL b2b_read_480: valid=%0b err=%0b data=%h, want 1 0 2222",
                                 rsp_valid, rsp_err, rsp_data);
                    end
                end
                3: begin
                    goto_ofs(511);
                    rvalid = 1'b1;
                    rdata  = 32'hFFFF_4444;
                    @(negedge clock);
                    rvalid = 1'b0;
                    n_vec++;
                    if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 16'h4444}) begin
                        n_bad++;
                        $display("FAIL b2b_read_511: valid=%0b err=%0b data=%h, want 1 0 4444",
                                 rsp_valid, rsp_err, rsp_data);
                    end
                end
                default: begin
                    goto_ofs(511);
                    n_vec++;
                    if (rsp_valid !== 1'b0) begin
                        n_bad++;
                        $display("FAIL b2b_timeout_early: rsp_valid=%0b want 0", rsp_valid);
                    end
                    @(negedge clock);
                    n_vec++;
                    if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b1, 16'h0}) begin
                        n_bad++;
                        $display("FAIL b2b_timeout: valid=%0b err=%0b data=%h, want 1 1 0000",
                                 rsp_valid, rsp_err, rsp_data);
                    end
                end
            endcase
        end
    endtask

    task automatic test_write();
        goto_ofs(100);
        push_req(1'b0, 4'h3, 16'hBEEF);
        goto_ofs(3);
        n_vec++;
        if ({wvalid, addr, wdata} !== {1'b1, 2'd0, 32'h0003_BEEF}) begin
            n_bad++;
            $display("FAIL write_issue: wvalid=%0b addr=%0d wdata=%h, want 1 0 0003beef",
                     wvalid, addr, wdata);
        end
        @(negedge clock);
        n_vec++;
        if (wvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL write_wvalid_pulse: wvalid=%0b at offset 4, want 0", wvalid);
        end
        goto_ofs(20);
        n_vec++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL write_ack_early: rsp_valid=%0b at offset 20, want 0", rsp_valid);
        end
        @(negedge clock);
        n_vec++;
        if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 16'h0}) begin
            n_bad++;
            $display("FAIL write_ack: valid=%0b err=%0b data=%h, want 1 0 0000",
                     rsp_valid, rsp_err, rsp_data);
        end
    endtask

    task automatic test_read();
        int early;
        goto_ofs(100);
        push_req(1'b1, 4'h5, 16'h0000);
        goto_ofs(3);
        n_vec++;
        if ({wvalid, addr, wdata} !== {1'b1, 2'd0, 32'h0015_0000}) begin
            n_bad++;
            $display("FAIL read_issue: wvalid=%0b addr=%0d wdata=%h, want 1 0 00150000",
                     wvalid, addr, wdata);
        end
        goto_ofs(386);
        early = 0;
        for (int i = 0; i < 8; i++) begin
            rvalid = 1'b1;
            rdata  = 32'hA5A5_0000 + 32'(i);
            @(negedge clock);
            if (rsp_valid) early++;
        end
        rvalid = 1'b0;
        @(negedge clock);
        if (rsp_valid) early++;
        n_vec++;
        if (early !== 0) begin
            n_bad++;
            $display("FAIL read_sample_beats: rsp_valid seen %0d times, want 0", early);
        end
        goto_ofs(497);
        rvalid = 1'b1;
        rdata  = 32'hDEAD_1234;
        @(negedge clock);
        rvalid = 1'b0;
        n_vec++;
        if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 16'h1234}) begin
            n_bad++;
            $display("FAIL read_rsp: valid=%0b err=%0b data=%h, want 1 0 1234",
                     rsp_valid, rsp_err, rsp_data);
        end
        @(negedge clock);
        n_vec++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL read_rsp_pulse: rsp_valid=%0b want 0", rsp_valid);
        end
    endtask

    task automatic test_cfg();
        goto_ofs(100);
        push_req(1'b0, 4'h9, 16'h0042);
        goto_ofs(2);
        cfg_valid = 1'b1;
        cfg_addr  = 2'd2;
        cfg_data  = 32'hCAFE_F00D;
        n_vec++;
        if (cfg_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL cfg_ready_blocked: cfg_ready=%0b want 0", cfg_ready);
        end
        @(negedge clock);
        n_vec++;
        if ({cfg_ready, wvalid, addr, wdata} !== {1'b1, 1'b1, 2'd0, 32'h0009_0042}) begin
            n_bad++;
            $display("FAIL cfg_cmd_first: cfg_ready=%0b wvalid=%0b addr=%0d wdata=%h, want 1 1 0 00090042",
                     cfg_ready, wvalid, addr, wdata);
        end
        @(negedge clock);
        cfg_valid = 1'b0;
        n_vec++;
        if ({wvalid, addr, wdata} !== {1'b1, 2'd2, 32'hCAFE_F00D}) begin
            n_bad++;
            $display("FAIL cfg_stream: wvalid=%0b addr=%0d wdata=%h, want 1 2 cafef00d",
                     wvalid, addr, wdata);
        end
        @(negedge clock);
        n_vec++;
        if (wvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL cfg_pulse: wvalid=%0b want 0", wvalid);
        end
        goto_ofs(21);
        n_vec++;
        if ({rsp_valid, rsp_err} !== 2'b10) begin
            n_bad++;
            $display("FAIL cfg_wack: valid=%0b err=%0b, want 1 0", rsp_valid, rsp_err);
        end
        goto_ofs(50);
        cfg_valid = 1'b1;
        cfg_addr  = 2'd3;
        cfg_data  = 32'h1357_9BDF;
        n_vec++;
        if (cfg_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL cfg_addr3_ready: cfg_ready=%0b want 1", cfg_ready);
        end
        @(negedge clock);
        cfg_valid = 1'b0;
        n_vec++;
        if (wvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL cfg_addr3_discard: wvalid=%0b want 0", wvalid);
        end
        goto_ofs(60);
        cfg_valid = 1'b1;
        cfg_addr  = 2'd1;
        cfg_data  = 32'h0000_0123;
        @(negedge clock);
        cfg_valid = 1'b0;
        n_vec++;
        if ({wvalid, addr, wdata} !== {1'b1, 2'd1, 32'h0000_0123}) begin
            n_bad++;
            $display("FAIL cfg_delay: wvalid=%0b addr=%0d wdata=%h, want 1 1 00000123",
                     wvalid, addr, wdata);
        end
    endtask

    task automatic test_reset_mid();
        int seen_wv;
        int seen_rsp;
        goto_ofs(100);
        push_req(1'b1, 4'hA, 16'h0000);
        goto_ofs(3);
        n_vec++;
        if ({wvalid, wdata} !== {1'b1, 32'h001A_0000}) begin
            n_bad++;
            $display("FAIL rst_mid_issue: wvalid=%0b wdata=%h, want 1 001a0000", wvalid, wdata);
        end
        goto_ofs(200);
        sync_en = 1'b0;
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        n_vec++;
        if ({wvalid, addr, wdata, rsp_valid, rsp_data, rsp_err} !== 52'd0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs: wvalid=%0b addr=%0d wdata=%h rsp_valid=%0b rsp_data=%h rsp_err=%0b, want all 0",
                     wvalid, addr, wdata, rsp_valid, rsp_data, rsp_err);
        end
        goto_ofs(210);
        push_req(1'b0, 4'hB, 16'h00BB);
        goto_ofs(497);
        rvalid = 1'b1;
        rdata  = 32'h0000_5555;
        @(negedge clock);
        rvalid = 1'b0;
        n_vec++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_rvalid: rsp_valid=%0b want 0", rsp_valid);
        end
        seen_wv  = 0;
        seen_rsp = 0;
        repeat (700) begin
            @(negedge clock);
            if (wvalid)    seen_wv++;
            if (rsp_valid) seen_rsp++;
        end
        n_vec++;
        if ({seen_wv, seen_rsp} !== {32'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL rst_mid_quiet: wvalid seen %0d rsp_valid seen %0d, want 0 0", seen_wv, seen_rsp);
        end
        goto_ofs(500);
        sync_en = 1'b1;
        goto_ofs(3);
        n_vec++;
        if ({wvalid, addr, wdata} !== {1'b1, 2'd0, 32'h000B_00BB}) begin
            n_bad++;
            $display("FAIL rst_mid_resume: wvalid=%0b addr=%0d wdata=%h, want 1 0 000b00bb",
                     wvalid, addr, wdata);
        end
        goto_ofs(21);
        n_vec++;
        if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 16'h0}) begin
            n_bad++;
            $display("FAIL rst_mid_ack: valid=%0b err=%0b data=%h, want 1 0 0000",
                     rsp_valid, rsp_err, rsp_data);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_write();
        test_read();
        test_cfg();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
